plru_alloc_ctrl: RTL and testbench

- Way-allocation controller for a WAYS-entry fully-associative structure.
- Tracks per-way valid bits and tree pseudo-LRU state; serves allocation requests with a registered victim way and eviction flag.
- Accepts hit-touch and invalidate updates from the lookup pipeline.
- Sits between the fill/miss handler (requester) and the tag/data arrays.

---
 rtl/plru_alloc_pkg.sv | 33 +++
 rtl/plru_alloc_ctrl_tree.sv | 78 +++++++
 rtl/plru_alloc_ctrl.sv | 123 ++++++++++++
 tb/tb_plru_alloc_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_alloc_pkg.sv
// Shared types and tree-index helpers for the PLRU way-allocation controller.
// Optional way locking is enabled by defining PLRU_ALLOC_LOCK_EN.
package plru_alloc_pkg;

  localparam int DEFAULT_WAYS = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // True when heap index 'node' is the leaf of 'way' or one of its ancestors.
  function automatic logic in_subtree(input int node, input int way, input int ways);
    int   idx;
    logic hit;
    idx = ways - 1 + way;
    hit = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (idx == node) hit = 1'b1;
      if (idx > 0) idx = (idx - 1) / 2;
    end
    return hit;
  endfunction

  function automatic logic node_on_path(input int node, input int way, input int ways);
    return in_subtree(node, way, ways);
  endfunction

  function automatic logic way_in_left(input int node, input int way, input int ways);
    return in_subtree(2 * node + 1, way, ways);
  endfunction

endpackage

// File: rtl/plru_alloc_ctrl_tree.sv
// Tree pseudo-LRU node register with touch/alloc update and lock-aware victim walk.
// Lock-aware walking is only exercised when PLRU_ALLOC_LOCK_EN is defined in the top.
module plru_tree_state
  import plru_alloc_pkg::*;
#(
  parameter int WAYS  = DEFAULT_WAYS,
  parameter int IDX_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_way,
  input  logic             alloc_en,
  input  logic [IDX_W-1:0] alloc_way,
  input  logic [WAYS-1:0]  lock_vec,
  output logic [IDX_W-1:0] victim
);

  logic [WAYS-2:0]  tree;
  logic [WAYS-2:0]  tree_nxt;
  logic [WAYS-2:0]  lock_l;
  logic [WAYS-2:0]  lock_r;
  logic [IDX_W-1:0] node_idx;
  logic [IDX_W-1:0] prefix;
  logic             go_right;

  // Allocation is applied after touch so it wins on shared nodes; clear wins over both.
  always_comb begin
    tree_nxt = tree;
    for (int n = 0; n < WAYS - 1; n++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (touch_en && touch_way == IDX_W'(w) && node_on_path(n, w, WAYS))
          tree_nxt[n] = way_in_left(n, w, WAYS);
      end
    end
    for (int n = 0; n < WAYS - 1; n++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (alloc_en && alloc_way == IDX_W'(w) && node_on_path(n, w, WAYS))
          tree_nxt[n] = way_in_left(n, w, WAYS);
      end
    end
    if (clear) tree_nxt = '0;
  end

  always_comb begin
    lock_l = '1;
    lock_r = '1;
    for (int n = 0; n < WAYS - 1; n++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (in_subtree(2 * n + 1, w, WAYS) && !lock_vec[w]) lock_l[n] = 1'b0;
        if (in_subtree(2 * n + 2, w, WAYS) && !lock_vec[w]) lock_r[n] = 1'b0;
      end
    end
  end

  // Walk level by level; the chosen directions form the victim index MSB first.
  always_comb begin
    node_idx = '0;
    prefix   = '0;
    go_right = 1'b0;
    for (int lvl = 0; lvl < IDX_W; lvl++) begin
      node_idx = IDX_W'((1 << lvl) - 1) + prefix;
      go_right = tree[node_idx];
      if (go_right && lock_r[node_idx])       go_right = 1'b0;
      else if (!go_right && lock_l[node_idx]) go_right = 1'b1;
      prefix = (prefix << 1) | IDX_W'(go_right);
    end
  end

  assign victim = prefix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tree <= '0;
    else        tree <= tree_nxt;
  end

endmodule

// File: rtl/plru_alloc_ctrl.sv
// Way-allocation controller: valid tracking, two-state grant FSM, PLRU victim choice.
// Define PLRU_ALLOC_LOCK_EN to add lock_vec / alloc_fail.
module plru_alloc_ctrl
  import plru_alloc_pkg::*;
#(
  parameter int WAYS  = DEFAULT_WAYS,
  parameter int IDX_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [IDX_W-1:0] alloc_way,
  output logic             alloc_evict,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_way,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_way,
  input  logic             inv_all,
`ifdef PLRU_ALLOC_LOCK_EN
  input  logic [WAYS-1:0]  lock_vec,
  output logic             alloc_fail,
`endif
  output logic [WAYS-1:0]  valid_vec,
  output logic             full
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             grant_upd;
  logic             fail_q;
  logic             all_locked;
  logic [WAYS-1:0]  lock_mask;
  logic [WAYS-1:0]  valid_nxt;
  logic             any_inv;
  logic [IDX_W-1:0] first_inv;
  logic [IDX_W-1:0] tree_victim;
  logic [IDX_W-1:0] victim;

`ifdef PLRU_ALLOC_LOCK_EN
  assign lock_mask  = lock_vec;
  assign all_locked = ~any_inv & (&lock_vec);
  assign alloc_fail = alloc_gnt & fail_q;
`else
  assign lock_mask  = '0;
  assign all_locked = 1'b0;
`endif

  plru_tree_state #(
    .WAYS  (WAYS),
    .IDX_W (IDX_W)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (inv_all),
    .touch_en  (touch_en),
    .touch_way (touch_way),
    .alloc_en  (grant_upd),
    .alloc_way (alloc_way),
    .lock_vec  (lock_mask),
    .victim    (tree_victim)
  );

  // Invalid ways always take precedence over the tree, lowest index first.
  always_comb begin
    any_inv   = 1'b0;
    first_inv = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) begin
        any_inv   = 1'b1;
        first_inv = IDX_W'(w);
      end
    end
  end

  assign victim    = any_inv ? first_inv : tree_victim;
  assign alloc_gnt = (state == GRANT);
  assign grant_upd = alloc_gnt & ~fail_q;
  assign full      = &valid_vec;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (alloc_req && !inv_all) begin
          accept    = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Priority lowest to highest: inv_en, grant-cycle allocation, inv_all.
  always_comb begin
    valid_nxt = valid_vec;
    if (inv_en)    valid_nxt[inv_way]   = 1'b0;
    if (grant_upd) valid_nxt[alloc_way] = 1'b1;
    if (inv_all)   valid_nxt            = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid_vec   <= '0;
      alloc_way   <= '0;
      alloc_evict <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      valid_vec <= valid_nxt;
      if (accept) begin
        alloc_way   <= victim;
        alloc_evict <= valid_vec[victim];
        fail_q      <= all_locked;
      end
    end
  end

endmodule

// File: tb/tb_plru_alloc_ctrl.sv
// Directed self-checking bench for plru_alloc_ctrl (WAYS=4).
// Lock scenarios are included when PLRU_ALLOC_LOCK_EN is defined.
module tb_plru_alloc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       alloc_req;
  logic       alloc_gnt;
  logic [1:0] alloc_way;
  logic       alloc_evict;
  logic       touch_en;
  logic [1:0] touch_way;
  logic       inv_en;
  logic [1:0] inv_way;
  logic       inv_all;
  logic [3:0] valid_vec;
  logic       full;
`ifdef PLRU_ALLOC_LOCK_EN
  logic [3:0] lock_vec;
  logic       alloc_fail;
`endif

  int checkCount = 0;
  int passCount  = 0;

  plru_alloc_ctrl #(.WAYS(4), .IDX_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_req   (alloc_req),
    .alloc_gnt   (alloc_gnt),
    .alloc_way   (alloc_way),
    .alloc_evict (alloc_evict),
    .touch_en    (touch_en),
    .touch_way   (touch_way),
    .inv_en      (inv_en),
    .inv_way     (inv_way),
    .inv_all     (inv_all),
`ifdef PLRU_ALLOC_LOCK_EN
    .lock_vec    (lock_vec),
    .alloc_fail  (alloc_fail),
`endif
    .valid_vec   (valid_vec),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    else
      passCount++;
  endtask

  // One-cycle strobes in an IDLE cycle.
  task automatic pulseUpdate(input logic tEn, input logic [1:0] tWay, input logic iEn,
                             input logic [1:0] iWay, input logic iAll);
    touch_en  = tEn;
    touch_way = tWay;
    inv_en    = iEn;
    inv_way   = iWay;
    inv_all   = iAll;
    @(negedge clk);
    touch_en = 1'b0;
    inv_en   = 1'b0;
    inv_all  = 1'b0;
  endtask

  // Request one allocation, check the grant, optionally inject strobes in the grant cycle.
  task automatic applyStimulus(input string tag, input logic [1:0] expWay, input logic expEvict,
                               input logic gTouch, input logic [1:0] gTouchWay,
                               input logic gInv, input logic [1:0] gInvWay, input logic gInvAll);
    int cyc;
    cyc = 0;
    alloc_req = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!alloc_gnt && cyc < 8);
    alloc_req = 1'b0;
    checkOutput({tag, "_gnt"}, 32'(alloc_gnt), 32'd1);
    checkOutput({tag, "_lat"}, 32'(cyc), 32'd1);
    checkOutput({tag, "_way"}, 32'(alloc_way), 32'(expWay));
    checkOutput({tag, "_evict"}, 32'(alloc_evict), 32'(expEvict));
`ifdef PLRU_ALLOC_LOCK_EN
    checkOutput({tag, "_fail"}, 32'(alloc_fail), 32'd0);
`endif
    touch_en  = gTouch;
    touch_way = gTouchWay;
    inv_en    = gInv;
    inv_way   = gInvWay;
    inv_all   = gInvAll;
    @(negedge clk);
    touch_en = 1'b0;
    inv_en   = 1'b0;
    inv_all  = 1'b0;
    checkOutput({tag, "_gnt_drop"}, 32'(alloc_gnt), 32'd0);
  endtask

  task automatic allocPlain(input string tag, input logic [1:0] expWay, input logic expEvict);
    applyStimulus(tag, expWay, expEvict, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic fillAll(input string tag);
    allocPlain({tag, "0"}, 2'd0, 1'b0);
    allocPlain({tag, "1"}, 2'd1, 1'b0);
    allocPlain({tag, "2"}, 2'd2, 1'b0);
    allocPlain({tag, "3"}, 2'd3, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    alloc_req = 1'b0;
    touch_en  = 1'b0;
    touch_way = 2'd0;
    inv_en    = 1'b0;
    inv_way   = 2'd0;
    inv_all   = 1'b0;
`ifdef PLRU_ALLOC_LOCK_EN
    lock_vec  = 4'b0000;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", 32'(alloc_gnt), 32'd0);
    checkOutput("rst_way", 32'(alloc_way), 32'd0);
    checkOutput("rst_evict", 32'(alloc_evict), 32'd0);
    checkOutput("rst_valid", 32'(valid_vec), 32'h0);
    checkOutput("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill in index order from empty.
    fillAll("fill");
    checkOutput("fill_valid", 32'(valid_vec), 32'hf);
    checkOutput("fill_full", 32'(full), 32'd1);

    // Tree after way 3: all nodes 0 -> victim way 0.
    allocPlain("evict0", 2'd0, 1'b1);

    // Flush, refill, touch way 0 -> root=1, node2=0 -> way 2.
    pulseUpdate(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    checkOutput("flush_valid", 32'(valid_vec), 32'h0);
    fillAll("refill");
    pulseUpdate(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    allocPlain("touch0", 2'd2, 1'b1);

    // Invalidate way 1 on a full structure.
    pulseUpdate(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
    checkOutput("inv1_valid", 32'(valid_vec), 32'hd);
    checkOutput("inv1_full", 32'(full), 32'd0);
    allocPlain("inv1", 2'd1, 1'b0);

    // Tree root=1, node2=1 -> way 3; same-way invalidate in the grant cycle loses.
    applyStimulus("gntinv", 2'd3, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
    checkOutput("gntinv_valid", 32'(valid_vec), 32'hf);

    // Touch way 1 -> way 2 victim; touch way 3 in grant cycle must not beat alloc on node2.
    pulseUpdate(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    applyStimulus("gnttouch", 2'd2, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    pulseUpdate(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    allocPlain("node2_probe", 2'd3, 1'b1);

    // Root=0, node1=1 -> way 1; flush during its grant cycle.
    applyStimulus("gntflush", 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    checkOutput("gntflush_valid", 32'(valid_vec), 32'h0);
    checkOutput("gntflush_full", 32'(full), 32'd0);
    allocPlain("postflush", 2'd0, 1'b0);

    // Flush in IDLE blocks acceptance for that cycle only.
    alloc_req = 1'b1;
    inv_all   = 1'b1;
    @(negedge clk);
    checkOutput("idleflush_nognt", 32'(alloc_gnt), 32'd0);
    inv_all = 1'b0;
    @(negedge clk);
    checkOutput("idleflush_gnt", 32'(alloc_gnt), 32'd1);
    checkOutput("idleflush_way", 32'(alloc_way), 32'd0);
    checkOutput("idleflush_evict", 32'(alloc_evict), 32'd0);
    alloc_req = 1'b0;
    @(negedge clk);

    // Request held across a grant is re-accepted in the following IDLE cycle.
    alloc_req = 1'b1;
    @(negedge clk);
    checkOutput("hold_gnt1", 32'(alloc_gnt), 32'd1);
    checkOutput("hold_way1", 32'(alloc_way), 32'd1);
    @(negedge clk);
    checkOutput("hold_idle", 32'(alloc_gnt), 32'd0);
    @(negedge clk);
    checkOutput("hold_gnt2", 32'(alloc_gnt), 32'd1);
    checkOutput("hold_way2", 32'(alloc_way), 32'd2);
    alloc_req = 1'b0;
    @(negedge clk);
    checkOutput("hold_valid", 32'(valid_vec), 32'h7);

    // Asynchronous reset in the middle of a grant cycle.
    alloc_req = 1'b1;
    @(negedge clk);
    checkOutput("arst_pre_gnt", 32'(alloc_gnt), 32'd1);
    checkOutput("arst_pre_way", 32'(alloc_way), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_gnt", 32'(alloc_gnt), 32'd0);
    checkOutput("arst_way", 32'(alloc_way), 32'd0);
    checkOutput("arst_valid", 32'(valid_vec), 32'h0);
    alloc_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("arst_after_gnt", 32'(alloc_gnt), 32'd0);
    checkOutput("arst_after_valid", 32'(valid_vec), 32'h0);

`ifdef PLRU_ALLOC_LOCK_EN
    // Full with all nodes 0: PLRU victim way 0 is locked -> way 1.
    fillAll("lfill");
    lock_vec = 4'b0001;
    allocPlain("lock1", 2'd1, 1'b1);
    lock_vec = 4'b1111;
    alloc_req = 1'b1;
    @(negedge clk);
    checkOutput("lockall_gnt", 32'(alloc_gnt), 32'd1);
    checkOutput("lockall_fail", 32'(alloc_fail), 32'd1);
    alloc_req = 1'b0;
    @(negedge clk);
    checkOutput("lockall_fail_drop", 32'(alloc_fail), 32'd0);
    checkOutput("lockall_valid", 32'(valid_vec), 32'hf);
    lock_vec = 4'b0000;
    // Tree untouched by the failed grant: root=1, node2=0 from way 1 alloc and earlier way 3.
    allocPlain("lockall_after", 2'd2, 1'b1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
